// File: rtl/i2cmb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2cmb_wb_sequencer
// Purpose  : Wishbone master that turns one I2C transaction request into the
//            iicmb CSR/DPR/CMDR register-access sequence.
// Revision : 1.0
// ============================================================================
module i2cmb_wb_sequencer #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_bus_i,
    input  logic [6:0]       req_addr_i,
    input  logic             req_rd_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             wdata_valid_i,
    input  logic [7:0]       wdata_i,
    output logic             wdata_ready_o,
    output logic             rdata_valid_o,
    output logic [7:0]       rdata_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             busy_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [1:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             ack_i,
    input  logic             irq_i
);
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE = 4'd0, S_EN  = 4'd1, S_DPR  = 4'd2, S_CMD  = 4'd3,
                           S_IRQ  = 4'd4, S_STS = 4'd5, S_WDAT = 4'd6, S_RDPR = 4'd7,
                           S_DONE = 4'd8;
    localparam logic [2:0] PH_BUS = 3'd0, PH_START = 3'd1, PH_ADDR = 3'd2,
                           PH_DATA = 3'd3, PH_STOP = 3'd4;
    localparam logic [7:0] CMD_WRITE = 8'h01, CMD_RDACK = 8'h02, CMD_RDNAK = 8'h03,
                           CMD_START = 8'h04, CMD_STOP = 8'h05, CMD_SETBUS = 8'h06;
    localparam logic [1:0] ST_OK = 2'b00, ST_NAK = 2'b01, ST_AL = 2'b10, ST_ERR = 2'b11;

    logic [3:0]       state_q, state_d;
    logic [2:0]       ph_q, ph_d;
    logic [7:0]       cmd_q, cmd_d, opnd_q, opnd_d, rdata_q, rdata_d;
    logic [3:0]       bus_q, bus_d, last_bus_q, last_bus_d;
    logic [6:0]       addr_q, addr_d;
    logic             rd_q, rd_d, rdv_q, rdv_d, ack_q, ack_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       pend_q, pend_d, status_q, status_d;
    logic             core_en_q, core_en_d, bus_valid_q, bus_valid_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic             w_wb, w_we, w_cyc, w_ack, w_stop;
    logic [1:0]       w_adr;
    logic [7:0]       w_dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ph_q        <= PH_BUS;
            cmd_q       <= 8'h00;
            opnd_q      <= 8'h00;
            rdata_q     <= 8'h00;
            bus_q       <= 4'h0;
            last_bus_q  <= 4'h0;
            addr_q      <= 7'h00;
            rd_q        <= 1'b0;
            rdv_q       <= 1'b0;
            ack_q       <= 1'b0;
            rem_q       <= '0;
            pend_q      <= ST_OK;
            status_q    <= ST_OK;
            core_en_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cmd_q       <= cmd_d;
            opnd_q      <= opnd_d;
            rdata_q     <= rdata_d;
            bus_q       <= bus_d;
            last_bus_q  <= last_bus_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            rdv_q       <= rdv_d;
            ack_q       <= ack_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            status_q    <= status_d;
            core_en_q   <= core_en_d;
            bus_valid_q <= bus_valid_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cmd_d       = cmd_q;
        opnd_d      = opnd_q;
        rdata_d     = rdata_q;
        bus_d       = bus_q;
        last_bus_d  = last_bus_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        rdv_d       = 1'b0;
        ack_d       = w_ack;
        rem_d       = rem_q;
        pend_d      = pend_q;
        status_d    = status_q;
        core_en_d   = core_en_q;
        bus_valid_d = bus_valid_q;
        tmo_d       = '0;
        w_stop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!core_en_q) begin
                    state_d = S_EN;
                end else if (req_valid_i) begin
                    bus_d  = req_bus_i;
                    addr_d = req_addr_i;
                    rd_d   = req_rd_i;
                    rem_d  = req_len_i;
                    pend_d = ST_OK;
                    if (bus_valid_q && req_bus_i == last_bus_q) begin
                        ph_d    = PH_START;
                        cmd_d   = CMD_START;
                        state_d = S_CMD;
                    end else begin
                        ph_d    = PH_BUS;
                        opnd_d  = {4'h0, req_bus_i};
                        cmd_d   = CMD_SETBUS;
                        state_d = S_DPR;
                    end
                end
            end
            S_EN: if (w_ack) begin
                core_en_d = 1'b1;
                state_d   = S_IDLE;
            end
            S_DPR: if (w_ack) state_d = S_CMD;
            S_CMD: if (w_ack) state_d = S_IRQ;
            S_IRQ: begin
                if (irq_i) begin
                    state_d = S_STS;
                end else if (tmo_q == TO_LAST) begin
                    pend_d      = ST_ERR;
                    core_en_d   = 1'b0;
                    bus_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_STS: if (w_ack) begin
                // Status bits: 7 DON, 6 NAK, 5 AL, 4 ERR
                if (dat_i[4]) begin
                    pend_d      = ST_ERR;
                    core_en_d   = 1'b0;
                    bus_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else if (dat_i[5]) begin
                    pend_d      = ST_AL;
                    bus_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else if (dat_i[6] && (ph_q == PH_ADDR || ph_q == PH_DATA)) begin
                    pend_d = ST_NAK;
                    w_stop = 1'b1;
                end else begin
                    case (ph_q)
                        PH_BUS: begin
                            bus_valid_d = 1'b1;
                            last_bus_d  = bus_q;
                            ph_d        = PH_START;
                            cmd_d       = CMD_START;
                            state_d     = S_CMD;
                        end
                        PH_START: begin
                            ph_d    = PH_ADDR;
                            opnd_d  = {addr_q, rd_q};
                            cmd_d   = CMD_WRITE;
                            state_d = S_DPR;
                        end
                        PH_ADDR: begin
                            if (rem_q == '0) begin
                                w_stop = 1'b1;
                            end else begin
                                ph_d = PH_DATA;
                                if (rd_q) begin
                                    cmd_d   = (rem_q == LEN_W'(1)) ? CMD_RDNAK : CMD_RDACK;
                                    state_d = S_CMD;
                                end else begin
                                    state_d = S_WDAT;
                                end
                            end
                        end
                        PH_DATA: begin
                            if (rd_q) begin
                                state_d = S_RDPR;
                            end else if (rem_q == LEN_W'(1)) begin
                                w_stop = 1'b1;
                            end else begin
                                rem_d   = rem_q - 1'b1;
                                state_d = S_WDAT;
                            end
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_WDAT: if (wdata_valid_i) begin
                opnd_d  = wdata_i;
                cmd_d   = CMD_WRITE;
                state_d = S_DPR;
            end
            S_RDPR: if (w_ack) begin
                rdata_d = dat_i;
                rdv_d   = 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    w_stop = 1'b1;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    cmd_d   = (rem_q == LEN_W'(2)) ? CMD_RDNAK : CMD_RDACK;
                    state_d = S_CMD;
                end
            end
            S_DONE: begin
                status_d = pend_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_stop) begin
            ph_d    = PH_STOP;
            cmd_d   = CMD_STOP;
            state_d = S_CMD;
        end
    end

    always_comb begin
        w_wb  = 1'b0;
        w_we  = 1'b0;
        w_adr = 2'd0;
        w_dat = 8'h00;
        case (state_q)
            S_EN:   begin w_wb = 1'b1; w_we = 1'b1; w_adr = 2'd0; w_dat = 8'hC0;  end
            S_DPR:  begin w_wb = 1'b1; w_we = 1'b1; w_adr = 2'd1; w_dat = opnd_q; end
            S_CMD:  begin w_wb = 1'b1; w_we = 1'b1; w_adr = 2'd2; w_dat = cmd_q;  end
            S_STS:  begin w_wb = 1'b1; w_adr = 2'd2; end
            S_RDPR: begin w_wb = 1'b1; w_adr = 2'd1; end
            default: ;
        endcase
        // One idle cycle after every ack keeps accesses separated on the bus
        w_cyc         = w_wb && !ack_q;
        w_ack         = w_cyc && ack_i;
        cyc_o         = w_cyc;
        stb_o         = w_cyc;
        we_o          = w_cyc && w_we;
        adr_o         = w_cyc ? w_adr : 2'd0;
        dat_o         = w_cyc ? w_dat : 8'h00;
        req_ready_o   = (state_q == S_IDLE) && core_en_q;
        wdata_ready_o = (state_q == S_WDAT);
        done_o        = (state_q == S_DONE);
        busy_o        = (state_q != S_IDLE) && (state_q != S_EN);
        status_o      = (state_q == S_DONE) ? pend_q : status_q;
        rdata_valid_o = rdv_q;
        rdata_o       = rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_i2cmb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2cmb_wb_sequencer
// Purpose  : Self-checking bench with an iicmb register/slave model.
// Revision : 1.0
// ============================================================================
module tb_i2cmb_wb_sequencer;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0, req_ready, req_rd = 1'b0;
    logic [3:0]       req_bus = 4'h0;
    logic [6:0]       req_addr = 7'h00;
    logic [LEN_W-1:0] req_len = '0;
    logic             wdata_valid = 1'b0, wdata_ready;
    logic [7:0]       wdata = 8'h00;
    logic             rdata_valid, done, busy, cyc, stb, we, ack = 1'b0, irq = 1'b0;
    logic [7:0]       rdata, wb_dat_w, wb_dat_r = 8'h00;
    logic [1:0]       status, adr;

    always #5 clk = ~clk;

    i2cmb_wb_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
        .req_addr_i(req_addr), .req_rd_i(req_rd), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .status_o(status),
        .busy_o(busy), .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr),
        .dat_o(wb_dat_w), .dat_i(wb_dat_r), .ack_i(ack), .irq_i(irq)
    );

    int total = 0;
    int bad   = 0;

    // Controller + I2C slave model
    logic [9:0] wlog[$];
    logic [7:0] rdq[$];
    logic [7:0] wq[$];
    logic [7:0] dpr_reg = 8'h00, resp = 8'h80;
    logic [6:0] present = 7'h22;
    int         irq_cnt = 0, wcount = 0, nak_at = 0;
    bit         exp_addr = 0, sc_al = 0, sc_err = 0, sc_hang = 0;

    task automatic cmd_resp(input logic [7:0] c);
        bit no_irq = 0;
        resp = 8'h80;
        case (c)
            8'h04: begin
                exp_addr = 1;
                wcount   = 0;
                if (sc_hang) no_irq = 1;
                else if (sc_al) resp = 8'h20;
                else if (sc_err) resp = 8'h10;
            end
            8'h01: begin
                if (exp_addr) begin
                    exp_addr = 0;
                    if (dpr_reg[7:1] != present) resp = 8'h40;
                end else begin
                    wcount++;
                    if (wcount == nak_at) resp = 8'h40;
                end
            end
            default: ;
        endcase
        irq_cnt = no_irq ? 0 : int'($urandom_range(1, 4));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            irq     <= 1'b0;
            irq_cnt = 0;
        end else begin
            ack <= 1'b0;
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) irq <= 1'b1;
            end
            if (cyc && stb && !ack) begin
                ack <= 1'b1;
                if (we) begin
                    wlog.push_back({adr, wb_dat_w});
                    if (adr == 2'd1) dpr_reg = wb_dat_w;
                    if (adr == 2'd2) cmd_resp(wb_dat_w);
                end else if (adr == 2'd2) begin
                    wb_dat_r <= resp;
                    irq      <= 1'b0;
                end else if (rdq.size() > 0) begin
                    wb_dat_r <= rdq.pop_front();
                end else begin
                    wb_dat_r <= 8'hEE;
                end
            end
        end
    end

    // Write-byte source and output monitor
    bit hs = 0;
    always @(negedge clk) begin
        if (hs && wq.size() > 0) void'(wq.pop_front());
        wdata_valid = (wq.size() > 0);
        wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
        hs          = wdata_valid && wdata_ready;
    end

    int         ncnt = 0, done_cnt = 0, last_cmd_n = 0, done_n = 0;
    logic [1:0] got_status = 2'b00;
    logic       got_busy = 1'b0;
    logic [7:0] got_rd[$];
    always @(negedge clk) begin
        ncnt++;
        if (cyc && ack && we && adr == 2'd2) last_cmd_n = ncnt;
        if (rdata_valid) got_rd.push_back(rdata);
        if (done) begin
            done_cnt++;
            got_status = status;
            got_busy   = busy;
            done_n     = ncnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected register writes, read bytes and status
    logic [7:0] tx_data[16];
    logic [9:0] exp_w[$];
    logic [7:0] exp_rd[$];
    logic [1:0] exp_st;
    bit         exp_to, m_en = 0, m_bv = 0;
    logic [3:0] m_last = 4'h0;

    task automatic model_exp(input logic [3:0] bus, input logic [6:0] addr, input bit rd, input int len);
        exp_w.delete();
        exp_rd.delete();
        exp_st = 2'b00;
        exp_to = 0;
        if (!m_en) begin exp_w.push_back({2'd0, 8'hC0}); m_en = 1; end
        if (!(m_bv && m_last == bus)) begin
            exp_w.push_back({2'd1, 4'h0, bus});
            exp_w.push_back({2'd2, 8'h06});
            m_bv = 1; m_last = bus;
        end
        exp_w.push_back({2'd2, 8'h04});
        if (sc_hang) begin exp_st = 2'b11; exp_to = 1; m_en = 0; m_bv = 0; return; end
        if (sc_al)   begin exp_st = 2'b10; m_bv = 0; return; end
        if (sc_err)  begin exp_st = 2'b11; m_en = 0; m_bv = 0; return; end
        exp_w.push_back({2'd1, addr, rd});
        exp_w.push_back({2'd2, 8'h01});
        if (addr != present) begin
            exp_w.push_back({2'd2, 8'h05});
            exp_st = 2'b01;
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (rd) begin
                exp_w.push_back({2'd2, (i == len - 1) ? 8'h03 : 8'h02});
                exp_rd.push_back(tx_data[i]);
            end else begin
                exp_w.push_back({2'd1, tx_data[i]});
                exp_w.push_back({2'd2, 8'h01});
                if (i + 1 == nak_at) begin exp_st = 2'b01; break; end
            end
        end
        exp_w.push_back({2'd2, 8'h05});
    endtask

    task automatic issue_req(input logic [3:0] bus, input logic [6:0] addr, input bit rd, input int len);
        int k = 0;
        while (!req_ready && k < 300) begin @(negedge clk); k++; end
        check("req_ready", {31'd0, req_ready}, 32'd1);
        req_bus = bus; req_addr = addr; req_rd = rd; req_len = LEN_W'(len);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("ready_while_busy", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [3:0] bus, input logic [6:0] addr,
                           input bit rd, input int len);
        int n, k, m;
        got_rd.delete(); rdq.delete(); wq.delete();
        for (int i = 0; i < len; i++) begin
            if (rd) rdq.push_back(tx_data[i]);
            else    wq.push_back(tx_data[i]);
        end
        model_exp(bus, addr, rd, len);
        n = done_cnt;
        issue_req(bus, addr, rd, len);
        k = 0;
        while (done_cnt == n && k < 3000) begin @(negedge clk); k++; end
        check({tag, " done_count"}, done_cnt - n, 32'd1);
        check({tag, " status"}, {30'd0, got_status}, {30'd0, exp_st});
        check({tag, " busy_at_done"}, {31'd0, got_busy}, 32'd1);
        @(negedge clk);
        check({tag, " status_held"}, {30'd0, status}, {30'd0, exp_st});
        if (exp_to) begin
            m = done_n - last_cmd_n;
            check({tag, " timeout_latency"}, {31'd0, (m >= 99 && m <= 103)}, 32'd1);
        end
        for (int i = 0; i < exp_w.size(); i++)
            check($sformatf("%s wr%0d", tag, i),
                  (i < wlog.size()) ? {22'd0, wlog[i]} : 32'hFFFF, {22'd0, exp_w[i]});
        for (int i = 0; i < exp_w.size() && wlog.size() > 0; i++) void'(wlog.pop_front());
        check({tag, " no_extra_wr"},
              {31'd0, (wlog.size() == 0) || (wlog.size() == 1 && wlog[0][9:8] == 2'd0)}, 32'd1);
        check({tag, " rd_count"}, got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("%s rd%0d", tag, i), {24'd0, got_rd[i]}, {24'd0, exp_rd[i]});
    endtask

    initial begin
        int k, n, len, r;
        bit rd;
        logic [3:0] bus;
        logic [6:0] addr;

        repeat (3) @(negedge clk);
        check("rst ready", {31'd0, req_ready}, 32'd0);
        check("rst cyc", {31'd0, cyc}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst status", {30'd0, status}, 32'd0);
        check("rst wready", {31'd0, wdata_ready}, 32'd0);
        check("rst rvalid", {31'd0, rdata_valid}, 32'd0);
        rst_n = 1'b1;

        present = 7'h22;
        tx_data[0] = 8'hB0; tx_data[1] = 8'hB1;
        run_txn("write2", 4'd0, 7'h22, 1'b0, 2);
        tx_data[0] = 8'd100; tx_data[1] = 8'd101; tx_data[2] = 8'd102;
        run_txn("read3", 4'd0, 7'h22, 1'b1, 3);
        run_txn("addr_nak", 4'd0, 7'h33, 1'b0, 2);
        check("addr_nak bytes_unused", wq.size(), 32'd2);
        wq.delete();
        sc_hang = 1;
        run_txn("timeout", 4'd0, 7'h22, 1'b0, 1);
        sc_hang = 0;
        run_txn("after_timeout", 4'd0, 7'h22, 1'b1, 1);
        run_txn("bus1_a", 4'd1, 7'h22, 1'b0, 1);
        run_txn("bus1_b", 4'd1, 7'h22, 1'b1, 2);
        run_txn("bus2", 4'd2, 7'h22, 1'b0, 1);
        run_txn("probe", 4'd2, 7'h22, 1'b0, 0);
        tx_data[2] = 8'h5A; tx_data[3] = 8'hA5;
        nak_at = 2;
        run_txn("data_nak", 4'd2, 7'h22, 1'b0, 4);
        nak_at = 0;
        wq.delete();
        sc_al = 1;
        run_txn("arb_lost", 4'd2, 7'h22, 1'b0, 1);
        sc_al = 0;
        sc_err = 1;
        run_txn("err", 4'd2, 7'h22, 1'b0, 1);
        sc_err = 0;

        // Reset while byte 2 of a read is in progress
        wlog.delete(); got_rd.delete(); rdq.delete();
        for (int i = 0; i < 3; i++) rdq.push_back(8'h70 + 8'(i));
        model_exp(4'd0, 7'h22, 1'b1, 3);
        n = done_cnt;
        issue_req(4'd0, 7'h22, 1'b1, 3);
        k = 0;
        while (!(got_rd.size() >= 1 && cyc && we && adr == 2'd2) && k < 500) begin
            @(negedge clk); k++;
        end
        check("midrst reached_byte2", {31'd0, (k < 500)}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst cyc", {31'd0, cyc}, 32'd0);
        check("midrst stb", {31'd0, stb}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrst no_done", done_cnt - n, 32'd0);
        wlog.delete(); wq.delete(); rdq.delete();
        m_en = 0; m_bv = 0;
        rst_n = 1'b1;
        tx_data[0] = 8'h11; tx_data[1] = 8'h22;
        run_txn("after_rst", 4'd0, 7'h22, 1'b0, 2);

        for (int t = 0; t < 20; t++) begin
            bus     = 4'($urandom_range(0, 2));
            present = 7'($urandom_range(8, 119));
            addr    = ($urandom_range(0, 4) == 0) ? (present ^ 7'h01) : present;
            rd      = 1'($urandom_range(0, 1));
            len     = int'($urandom_range(0, 5));
            for (int i = 0; i < 16; i++) tx_data[i] = 8'($urandom);
            r = int'($urandom_range(0, 9));
            sc_al  = (r == 0);
            sc_err = (r == 1);
            nak_at = (r == 2 && !rd && len > 0) ? int'($urandom_range(1, len)) : 0;
            run_txn($sformatf("rand%0d", t), bus, addr, rd, len);
            sc_al = 0; sc_err = 0; nak_at = 0;
            wq.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
